// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: ALU operators, 8XYn sequencer states and opcode decode.
// OP8_VF_RESET_QUIRK_EN makes OR/AND/XOR also write VF=0 (COSMAC behaviour).
package chip8_pkg;

  localparam logic [3:0] FLAG_REG_DEFAULT = 4'hF;

`ifdef OP8_VF_RESET_QUIRK_EN
  localparam logic VF_RESET_QUIRK = 1'b1;
`else
  localparam logic VF_RESET_QUIRK = 1'b0;
`endif

  typedef enum logic [3:0] {
    OP_SET,
    OP_OR,
    OP_AND,
    OP_XOR,
    OP_SUM,
    OP_SUB,
    OP_SHIFT_RIGHT,
    OP_NEG_SUB,
    OP_SHIFT_LEFT
  } operator_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_X,
    ST_RD_Y,
    ST_LATCH,
    ST_WR_X,
    ST_WR_F,
    ST_DONE
  } op8_state_t;

  typedef struct packed {
    operator_t op;
    logic      legal;
    logic      writes_flag;
  } op_decode_t;

  function automatic op_decode_t decode_n(input logic [3:0] n);
    op_decode_t d;
    d.op          = OP_SET;
    d.legal       = 1'b1;
    d.writes_flag = 1'b0;
    case (n)
      4'h0: d.op = OP_SET;
      4'h1: begin d.op = OP_OR;          d.writes_flag = VF_RESET_QUIRK; end
      4'h2: begin d.op = OP_AND;         d.writes_flag = VF_RESET_QUIRK; end
      4'h3: begin d.op = OP_XOR;         d.writes_flag = VF_RESET_QUIRK; end
      4'h4: begin d.op = OP_SUM;         d.writes_flag = 1'b1; end
      4'h5: begin d.op = OP_SUB;         d.writes_flag = 1'b1; end
      4'h6: begin d.op = OP_SHIFT_RIGHT; d.writes_flag = 1'b1; end
      4'h7: begin d.op = OP_NEG_SUB;     d.writes_flag = 1'b1; end
      4'hE: begin d.op = OP_SHIFT_LEFT;  d.writes_flag = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/op8_sequencer_alu.sv
// Shared 8-bit CHIP-8 ALU: result plus flag (carry out, no-borrow, or shifted-out bit).
module alu
  import chip8_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  operator_t  i_op,
  output logic [7:0] o_y,
  output logic       o_carry
);

  logic [8:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Operator select; shifts act on the second operand
  always_comb begin
    o_y     = 8'h00;
    o_carry = 1'b0;
    case (i_op)
      OP_SET:         o_y = i_b;
      OP_OR:          o_y = i_a | i_b;
      OP_AND:         o_y = i_a & i_b;
      OP_XOR:         o_y = i_a ^ i_b;
      OP_SUM:         begin o_y = w_sum[7:0]; o_carry = w_sum[8]; end
      OP_SUB:         begin o_y = i_a - i_b; o_carry = (i_a >= i_b); end
      OP_SHIFT_RIGHT: begin o_y = {1'b0, i_b[7:1]}; o_carry = i_b[0]; end
      OP_NEG_SUB:     begin o_y = i_b - i_a; o_carry = (i_b >= i_a); end
      OP_SHIFT_LEFT:  begin o_y = {i_b[6:0], 1'b0}; o_carry = i_b[7]; end
      default:        begin o_y = 8'h00; o_carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/op8_sequencer.sv
// CHIP-8 8XYn sequencer: read Vx/Vy, run the ALU, write Vx then VF.
// OP8_VF_RESET_QUIRK_EN (see chip8_pkg) routes OR/AND/XOR through the VF write.
module op8_sequencer
  import chip8_pkg::*;
#(
  parameter int                    REG_ADDR_W = 4,
  parameter logic [REG_ADDR_W-1:0] FLAG_REG   = REG_ADDR_W'(FLAG_REG_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [REG_ADDR_W-1:0] x,
  input  logic [REG_ADDR_W-1:0] y,
  input  logic [3:0]            n,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [7:0]            rf_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [7:0]            rf_wdata
);

  op8_state_t            r_state;
  op8_state_t            w_next_state;
  logic [REG_ADDR_W-1:0] r_x;
  logic [REG_ADDR_W-1:0] r_y;
  logic [3:0]            r_n;
  logic [7:0]            r_a;
  logic [7:0]            r_b;
  logic                  r_flag;
  logic                  r_illegal;

  logic [3:0]            w_n_sel;
  op_decode_t            w_dec;
  logic [7:0]            w_alu_y;
  logic                  w_alu_carry;
  logic                  w_we;

  // One decoder serves both the accept decision (live n) and execution (latched n)
  assign w_n_sel = (r_state == ST_IDLE) ? n : r_n;
  assign w_dec   = decode_n(w_n_sel);

  alu u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (w_dec.op),
    .o_y     (w_alu_y),
    .o_carry (w_alu_carry)
  );

  // State register and operand/flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_n       <= 4'h0;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_flag    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x       <= x;
            r_y       <= y;
            r_n       <= n;
            r_illegal <= ~w_dec.legal;
          end
        end
        ST_RD_Y:  r_a    <= rf_rdata;
        ST_LATCH: r_b    <= rf_rdata;
        ST_WR_X:  r_flag <= w_alu_carry;
        default:  ;
      endcase
    end
  end

  // Next-state and output decode from the registered state
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    illegal      = 1'b0;
    rf_raddr     = '0;
    w_we         = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start && w_dec.legal) begin
          w_next_state = ST_RD_X;
        end else if (start) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_X: begin
        rf_raddr     = r_x;
        w_next_state = ST_RD_Y;
      end
      ST_RD_Y: begin
        rf_raddr     = r_y;
        w_next_state = ST_LATCH;
      end
      ST_LATCH: w_next_state = ST_WR_X;
      ST_WR_X: begin
        w_we     = 1'b1;
        rf_waddr = r_x;
        rf_wdata = w_alu_y;
        if (w_dec.writes_flag) begin
          w_next_state = ST_WR_F;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_WR_F: begin
        w_we         = 1'b1;
        rf_waddr     = FLAG_REG;
        rf_wdata     = {7'b0000000, r_flag};
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        illegal      = r_illegal;
        w_next_state = ST_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // A reset arriving mid-operation must not let the pending write through
  assign rf_we = w_we & ~rst;

endmodule

// File: doc/op8_sequencer.md
Name: op8_sequencer

Overview:
- Executes one CHIP-8 8XYn register-register instruction per request.
- Reads Vx and Vy from the V register file, drives the shared 8-bit ALU, writes the result back to Vx, then writes VF with the flag.
- Sits between instruction decode and the V register file; it is the only master of the ALU and of the register-file port while busy.
- VF is always written after Vx, so for x=F the flag wins (standard CHIP-8 ordering).

Parameters:
- REG_ADDR_W, 4, V register address width (16 registers).
- FLAG_REG, 4'hF, register index receiving the carry/borrow/shift-out flag.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE only
- x  in  4  destination/first operand index, sampled on accept
- y  in  4  second operand index, sampled on accept
- n  in  4  opcode low nibble, sampled on accept
- busy  out  1  high from the cycle after accept until DONE inclusive
- done  out  1  one-cycle pulse at completion
- illegal  out  1  valid with done; 1 when n is unsupported
- rf_raddr  out  4  register file read address; read data valid one cycle after the address is presented
- rf_rdata  in  8  register file read data
- rf_we  out  1  register file write enable
- rf_waddr  out  4  register file write address
- rf_wdata  out  8  register file write data

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, done=0, illegal=0, rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, internal x/y/n/a/b/flag registers=0.
- n to operator mapping:
  - 0 SET, 1 OR, 2 AND, 3 XOR, 4 SUM, 5 SUB (Vx-Vy), 6 SHIFT_RIGHT, 7 NEG_SUB (Vy-Vx), E SHIFT_LEFT.
  - Every other n is illegal.
- ALU operands: a=Vx, b=Vy. Shifts operate on Vy.
- States: IDLE -> RD_X -> RD_Y -> LATCH -> WR_X -> WR_F -> DONE -> IDLE.
- IDLE:
  - On start: latch x, y, n.
  - If n is illegal, go to DONE with illegal_q=1 and make no register-file writes.
  - Otherwise go to RD_X.
- RD_X: rf_raddr=x.
- RD_Y: rf_raddr=y; a_q<=rf_rdata.
- LATCH: b_q<=rf_rdata.
- WR_X: rf_we=1, rf_waddr=x, rf_wdata=ALU out; flag_q<=ALU carry.
- WR_F:
  - Entered only for flag-writing ops (SUM, SUB, SHIFT_RIGHT, NEG_SUB, SHIFT_LEFT, plus OR/AND/XOR when the optional feature is enabled).
  - rf_we=1, rf_waddr=FLAG_REG, rf_wdata={7'b0,flag_q}.
  - Otherwise WR_X goes straight to DONE.
- DONE: done=1 and illegal=illegal_q for one cycle, then IDLE.
- Latency from the accept cycle T:
  - Flag ops: done at T+6.
  - SET, and OR/AND/XOR without the feature: done at T+5.
  - Illegal: done at T+1.
- start while busy is ignored, with no queueing. start in the DONE cycle is ignored; ready rises in the following IDLE cycle.
- rf_we is high only in WR_X/WR_F, for exactly one cycle each.
- x==y: both reads return the same value; the result is computed normally (e.g. 8XX5 gives Vx=0, VF=1).
- Reset asserted mid-operation: return to IDLE next cycle and suppress any pending write. No write occurs in the cycle rst is high.
- Arithmetic is 8-bit with wrap; flag semantics are the ALU's (carry out, no-borrow=1, shifted-out bit).

Optional Feature:
- Macro: OP8_VF_RESET_QUIRK_EN.
- Defined: OR/AND/XOR go through WR_F and write VF=0 (COSMAC behaviour).
- Undefined: SET/OR/AND/XOR never touch VF.

Decomposition:
- Shared package chip8_pkg holds:
  - the operator_t enum (SET, OR, AND, XOR, SUM, SUB, SHIFT_RIGHT, NEG_SUB, SHIFT_LEFT);
  - the op8 state enum;
  - the FLAG_REG default constant;
  - a function mapping n to {operator_t, legal, writes_flag}.
- One sub-module: the existing alu, instantiated once with a=a_q, b=b_q, operator from the latched n.

Test Plan:
- V1=0xF0, V2=0x20, start x=1 y=2 n=4 -> V1=0x10 at T+4, VF=1 at T+5, done at T+6, illegal=0.
- V3=0x05, V4=0x07, n=5 -> V3=0xFE, VF=0; then n=7 on the same registers with V3 reloaded to 0x05 -> V3=0x02, VF=1.
- VF=0x80, x=F, y=F, n=E -> first write VF=0x00, then VF=0x01; the flag write is last.
- n=0x9 -> done at T+1 with illegal=1; no rf_we during the whole operation; ready again at T+2.
- OR with V5=0x0F, V6=0xF0, VF=0x77 -> V5=0xFF. VF=0x77 and done at T+5 without the macro; VF=0x00 and done at T+6 with it.
- Assert rst in the LATCH state of a SUM, then pulse start during busy on a separate run -> no write after reset, outputs at reset values; the extra start is ignored with exactly one done per accepted request.
